grey_code6_rx: RTL

Receiving end of the 6-bit grey-count link driven by the divider/grey generator.
- Samples an incoming 6-bit grey code through a synchronizer and decodes it to binary.
- Checks that every change is a single +1 step (mod 64) arriving at the expected interval.
- Emits a step pulse, a saturating step count and sticky error flags to the user-project status logic.

---
 rtl/grey_pkg.sv | 14 +
 rtl/grey_sync_ff.sv | 16 +
 rtl/grey_code6_rx.sv | 80 ++++++++
 3 files changed

// File: rtl/grey_pkg.sv
// grey_pkg: shared state encoding, counter limits and grey/binary conversion helpers.
package grey_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_e;
  localparam int PER_SAT = 255;
  function automatic logic [5:0] f_grey6(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [5:0] f_bin6(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/grey_sync_ff.sv
// grey_sync_ff: N-stage, WIDTH-bit synchronizer with asynchronous reset.
module grey_sync_ff #(
  parameter int N = 2,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [N-1:0][WIDTH-1:0] ff_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff_q <= '0;
    else ff_q <= {ff_q[N-2:0], d_i};
  assign q_o = ff_q[N-1];
endmodule

// File: rtl/grey_code6_rx.sv
// grey_code6_rx: synchronizes and decodes a 6-bit grey count, checks +1 steps and their period.
module grey_code6_rx
  import grey_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD = 7,
  parameter int CNT_W = 16
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] grey_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin,
  output logic             incr,
  output logic [CNT_W-1:0] step_cnt,
  output logic             err_skip,
  output logic             err_period
);
  logic [1:0] rst_sync_q;
  logic rst_int;
  logic [WIDTH-1:0] g_s, bin_new, bin_q;
  logic [7:0] per_cnt_q, per_cnt_d;
  logic [1:0] fill_q;
  logic [CNT_W-1:0] step_cnt_q;
  logic incr_q, err_skip_q, err_period_q, chg, step, tmo;
  state_e st_q;
  // reset asserts asynchronously but is released on a clock edge
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_sync_q <= 2'b11;
    else rst_sync_q <= {rst_sync_q[0], 1'b0};
  assign rst_int = rst_sync_q[1];
  grey_sync_ff #(.N(SYNC_STAGES), .WIDTH(WIDTH)) u_sync (
    .clk(clk), .rst(rst_int), .d_i(grey_in), .q_o(g_s)
  );
  assign bin_new = f_bin6(g_s);
  assign chg = st_q != IDLE && bin_new != bin_q;
  assign step = chg && bin_new == bin_q + 6'd1;
  assign tmo = st_q == LOCKED && !chg && per_cnt_q >= 8'(2 * EXP_PERIOD);
  assign per_cnt_d = chg ? 8'd1 : per_cnt_q + {7'd0, per_cnt_q != 8'(PER_SAT)};
  always_ff @(posedge clk or posedge rst_int)
    if (rst_int) begin
      st_q <= IDLE;
      fill_q <= '0;
      bin_q <= '0;
      per_cnt_q <= '0;
      step_cnt_q <= '0;
      incr_q <= 1'b0;
      err_skip_q <= 1'b0;
      err_period_q <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      incr_q <= step;
      if (step && step_cnt_q != '1) step_cnt_q <= step_cnt_q + 1'b1;
      err_skip_q <= (err_skip_q && !clr_err) || (chg && !step);
      err_period_q <= (err_period_q && !clr_err) || tmo ||
                      (step && st_q == LOCKED && per_cnt_q != 8'(EXP_PERIOD));
      if (chg) bin_q <= bin_new;
      case (st_q)
        IDLE: begin
          fill_q <= fill_q + 2'd1;
          if (fill_q == 2'(SYNC_STAGES)) begin
            bin_q <= bin_new;
            st_q <= ARMED;
          end
        end
        ARMED: if (step) st_q <= LOCKED;
        default: if ((chg && !step) || tmo) st_q <= ARMED;
      endcase
    end
  assign bin = bin_q;
  assign incr = incr_q;
  assign step_cnt = step_cnt_q;
  assign err_skip = err_skip_q;
  assign err_period = err_period_q;
endmodule
